// File: rtl/pcie_lane_train_ctrl.sv
// pcie_lane_train_ctrl: receive-side PCIe lane training (symbol lock, polarity, lane order)
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Start             one-cycle pulse that (re)starts training when not Busy
//   LinkInVec         raw 10-bit symbols, lane i at [10i+9:10i]
//   ElecIdleIn        per-lane electrical idle
//   InvertIn          receive polarity decision driven to the host
//   ReverseIn         receive lane-reversal decision driven to the host
//   LaneLocked        per-lane symbol lock
//   Busy, Done, Fail  training in progress / succeeded (sticky) / failed (sticky)
module pcie_lane_train_ctrl #(
    parameter int         LinkWidth      = 16,
    parameter int         LockCount      = 8,
    parameter int         TimeoutCycles  = 4096,
    parameter logic [9:0] ComRdNeg       = 10'h17C,
    parameter logic [9:0] TsIdNorm       = 10'h155,
    parameter logic [9:0] TsIdInv        = 10'h2AA,
    parameter logic [9:0] LaneNum0Sym    = 10'h0C5,
    parameter logic [9:0] LaneNumLastSym = 10'h0DA
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [10*LinkWidth-1:0] LinkInVec,
    input  logic [LinkWidth-1:0]    ElecIdleIn,
    output logic                    InvertIn,
    output logic                    ReverseIn,
    output logic [LinkWidth-1:0]    LaneLocked,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Fail
);
    typedef enum logic [2:0] {IDLE, HUNT, POLARITY, REVERSE, DONE, FAIL} stateT;
    localparam int TimerW = $clog2(TimeoutCycles + 1);
    stateT state;
    logic [TimerW-1:0] timer;
    logic [LinkWidth-1:0] activeMask, voted, voteInv;
    logic [3:0] symPos [LinkWidth];
    logic [3:0] lockCnt [LinkWidth];
    logic [3:0] symPosNxt [LinkWidth];
    logic [3:0] lockCntNxt [LinkWidth];
    logic [LinkWidth-1:0] lockNxt, isCom, isNorm, isInv, atSix, newVote;
    logic [9:0] loSym, revSym;
    logic [3:0] loPos;
    logic allLocked, allVoted, allInv, allNorm, tracking, timeUp;

    // SymPos==0 is the slot where the next COM is due: a COM there extends the
    // lock run, a COM elsewhere realigns, and no COM there drops the run.
    always_comb begin
        for (int i = 0; i < LinkWidth; i++) begin
            isCom[i] = LinkInVec[10*i +: 10] == ComRdNeg || LinkInVec[10*i +: 10] == ~ComRdNeg;
            isNorm[i] = LinkInVec[10*i +: 10] == TsIdNorm;
            isInv[i] = LinkInVec[10*i +: 10] == TsIdInv;
            atSix[i] = symPos[i] == 4'd6;
            symPosNxt[i] = isCom[i] ? 4'd1 : symPos[i] + 4'd1;
            lockCntNxt[i] = ElecIdleIn[i] ? 4'd0 :
                            isCom[i] ? (symPos[i] != 4'd0 ? 4'd1 :
                                        lockCnt[i] == 4'(LockCount) ? lockCnt[i] : lockCnt[i] + 4'd1) :
                            symPos[i] == 4'd0 ? 4'd0 : lockCnt[i];
            lockNxt[i] = lockCntNxt[i] == 4'(LockCount);
        end
    end

    // Lowest-numbered active lane carries the lane number that reveals reversal.
    always_comb begin
        loSym = LinkInVec[9:0];
        loPos = symPos[0];
        for (int i = LinkWidth - 1; i >= 0; i--) begin
            if (activeMask[i]) begin
                loSym = LinkInVec[10*i +: 10];
                loPos = symPos[i];
            end
        end
    end

    assign revSym    = loSym ^ {10{InvertIn}};
    assign newVote   = activeMask & ~voted & atSix & (isNorm | isInv);
    assign allLocked = (LaneLocked & activeMask) == activeMask;
    assign allVoted  = (voted & activeMask) == activeMask;
    assign allInv    = (voteInv & activeMask) == activeMask;
    assign allNorm   = (voteInv & activeMask) == '0;
    assign tracking  = state != IDLE && state != FAIL;
    assign timeUp    = timer == TimerW'(TimeoutCycles - 1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            timer <= '0;
            activeMask <= '0;
            voted <= '0;
            voteInv <= '0;
            InvertIn <= 1'b0;
            ReverseIn <= 1'b0;
            LaneLocked <= '0;
            Busy <= 1'b0;
            Done <= 1'b0;
            Fail <= 1'b0;
            for (int i = 0; i < LinkWidth; i++) begin
                symPos[i] <= '0;
                lockCnt[i] <= '0;
            end
        end else begin
            if (tracking) begin
                for (int i = 0; i < LinkWidth; i++) begin
                    symPos[i] <= symPosNxt[i];
                    lockCnt[i] <= lockCntNxt[i];
                end
                LaneLocked <= lockNxt;
            end
            if (Start && !Busy) begin
                activeMask <= ~ElecIdleIn;
                InvertIn <= 1'b0;
                ReverseIn <= 1'b0;
                Done <= 1'b0;
                if (&ElecIdleIn) begin
                    state <= FAIL;
                    Fail <= 1'b1;
                end else begin
                    state <= HUNT;
                    Busy <= 1'b1;
                    Fail <= 1'b0;
                    timer <= '0;
                    voted <= '0;
                    voteInv <= '0;
                    LaneLocked <= '0;
                    for (int i = 0; i < LinkWidth; i++) begin
                        symPos[i] <= '0;
                        lockCnt[i] <= '0;
                    end
                end
            end else if (Busy) begin
                timer <= timer + TimerW'(1);
                if (timeUp) begin
                    state <= FAIL;
                    Busy <= 1'b0;
                    Fail <= 1'b1;
                    InvertIn <= 1'b0;
                    ReverseIn <= 1'b0;
                end else if (state != HUNT && !allLocked) begin
                    state <= HUNT;
                    voted <= '0;
                    voteInv <= '0;
                end else if (state == HUNT) begin
                    if (allLocked) state <= POLARITY;
                end else if (state == POLARITY) begin
                    if (!allVoted) begin
                        voted <= voted | newVote;
                        voteInv <= voteInv | (newVote & isInv);
                    end else if (allInv || allNorm) begin
                        InvertIn <= allInv;
                        state <= REVERSE;
                    end else begin
                        state <= FAIL;
                        Busy <= 1'b0;
                        Fail <= 1'b1;
                        InvertIn <= 1'b0;
                        ReverseIn <= 1'b0;
                    end
                end else if (loPos == 4'd2 && (revSym == LaneNum0Sym || revSym == LaneNumLastSym)) begin
                    ReverseIn <= revSym == LaneNumLastSym;
                    state <= DONE;
                    Busy <= 1'b0;
                    Done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pcie_lane_train_ctrl.sv
// tb_pcie_lane_train_ctrl: directed checks of lane lock, polarity, reversal, timeout and reset
module tb_pcie_lane_train_ctrl;
    localparam logic [9:0] Com = 10'h17C, IdN = 10'h155, IdI = 10'h2AA;
    localparam logic [9:0] Ln0 = 10'h0C5, LnL = 10'h0DA, Fill = 10'h04A;

    typedef struct {
        bit         inv;
        bit         mis;
        bit         pulse;
        int         rl;
        logic [9:0] lSym;
        logic [9:0] l1Id;
        logic [15:0] idle;
        bit         eDone;
        bit         eFail;
        bit         eInv;
        bit         eRev;
        logic [15:0] eLock;
        int         eRel;
    } vecT;

    logic Clk = 1'b0;
    logic Reset = 1'b1, Start = 1'b0, StartT = 1'b0;
    logic [159:0] LinkInVec = '0;
    logic [15:0] ElecIdleIn = 16'hFFF0;
    logic InvertIn, ReverseIn, Busy, Done, Fail;
    logic [15:0] LaneLocked;
    logic InvertT, ReverseT, BusyT, DoneT, FailT;
    logic [3:0] LockedT;
    int nChecks = 0, nFails = 0, cyc = 0, slot = 0, comCnt = 0, e1 = 0, lockRel = 0, revLane = 0;
    bit inv = 1'b0, noCom = 1'b0, misEn = 1'b0;
    logic [9:0] laneSym = Ln0, lane1Id = IdN;
    vecT vecs [5];

    always #5 Clk = ~Clk;

    pcie_lane_train_ctrl #(.LinkWidth(16), .LockCount(8), .TimeoutCycles(1024)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .LinkInVec(LinkInVec), .ElecIdleIn(ElecIdleIn),
        .InvertIn(InvertIn), .ReverseIn(ReverseIn), .LaneLocked(LaneLocked),
        .Busy(Busy), .Done(Done), .Fail(Fail));

    pcie_lane_train_ctrl #(.LinkWidth(4), .LockCount(8), .TimeoutCycles(256)) dutT (
        .Clk(Clk), .Reset(Reset), .Start(StartT), .LinkInVec(LinkInVec[39:0]), .ElecIdleIn(ElecIdleIn[3:0]),
        .InvertIn(InvertT), .ReverseIn(ReverseT), .LaneLocked(LockedT),
        .Busy(BusyT), .Done(DoneT), .Fail(FailT));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Training set: COM at slot 0, lane number at slot 2, TS identifier at slot 6.
    task automatic drive();
        for (int i = 0; i < 16; i++) begin
            logic [9:0] s;
            s = Fill;
            if (slot == 0 && !noCom) s = Com;
            if (slot == 2) s = (i == revLane) ? laneSym : (10'h100 | 10'(i));
            if (slot == 6) s = (i == 1) ? lane1Id : IdN;
            if (misEn && i == 2 && slot == 9 && comCnt == 5) s = Com;
            LinkInVec[10*i +: 10] = s ^ {10{inv}};
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        slot = (slot + 1) % 16;
        if (slot == 0 && !noCom) comCnt++;
        drive();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 0, Ln0, IdN, 16'hFFF0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000F, 113};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, LnL, IdN, 16'hFFF0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000F, 113};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 0, Ln0, IdN, 16'hFFF0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000F, 193};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 0, Ln0, IdI, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000F, 113};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1, LnL, IdN, 16'hFFF1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000E, 113};
        drive();
        for (int v = 0; v < 5; v++) begin
            inv = vecs[v].inv;
            misEn = vecs[v].mis;
            revLane = vecs[v].rl;
            laneSym = vecs[v].lSym;
            lane1Id = vecs[v].l1Id;
            ElecIdleIn = vecs[v].idle;
            Reset = 1'b1;
            tick();
            Reset = 1'b0;
            chk($sformatf("v%0d reset", v), 32'({Busy, Done, Fail, InvertIn, ReverseIn, |LaneLocked}), 32'd0);
            while (slot != 15) tick();
            Start = 1'b1;
            comCnt = 0;
            tick();
            e1 = cyc;
            Start = 1'b0;
            chk($sformatf("v%0d busy rise", v), 32'(Busy), 32'd1);
            lockRel = -1;
            for (int k = 1; k <= 400 && !(Done || Fail); k++) begin
                Start = vecs[v].pulse && k == 50;
                tick();
                if (lockRel < 0 && LaneLocked == vecs[v].eLock) lockRel = cyc - e1;
            end
            Start = 1'b0;
            chk($sformatf("v%0d done", v), 32'(Done), 32'(vecs[v].eDone));
            chk($sformatf("v%0d fail", v), 32'(Fail), 32'(vecs[v].eFail));
            chk($sformatf("v%0d invert", v), 32'(InvertIn), 32'(vecs[v].eInv));
            chk($sformatf("v%0d reverse", v), 32'(ReverseIn), 32'(vecs[v].eRev));
            chk($sformatf("v%0d locked", v), 32'(LaneLocked), 32'(vecs[v].eLock));
            chk($sformatf("v%0d busy end", v), 32'(Busy), 32'd0);
            chk($sformatf("v%0d lock time", v), lockRel, vecs[v].eRel);
        end

        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart busy", 32'(Busy), 32'd1);
        chk("restart done clr", 32'(Done), 32'd0);
        chk("restart rev clr", 32'(ReverseIn), 32'd0);
        chk("restart lock clr", 32'(LaneLocked), 32'd0);
        for (int k = 0; k < 200 && LaneLocked != 16'h000E; k++) tick();
        chk("relock", 32'(LaneLocked), 32'h000E);
        tick();
        tick();
        chk("in polarity busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("reset in polarity", 32'({Busy, Done, Fail, InvertIn, ReverseIn, |LaneLocked}), 32'd0);
        ElecIdleIn = 16'hFFFF;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("all idle fail", 32'(Fail), 32'd1);
        chk("all idle busy", 32'(Busy), 32'd0);
        tick();
        chk("fail sticky", 32'(Fail), 32'd1);
        ElecIdleIn = 16'hFFF0;
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        chk("reset beats start", 32'({Busy, Fail}), 32'd0);

        noCom = 1'b1;
        StartT = 1'b1;
        tick();
        e1 = cyc;
        StartT = 1'b0;
        chk("timeout busy rise", 32'(BusyT), 32'd1);
        for (int k = 0; k < 300 && !FailT; k++) tick();
        chk("timeout cycles", cyc - e1, 256);
        chk("timeout fail", 32'(FailT), 32'd1);
        chk("timeout busy", 32'(BusyT), 32'd0);
        chk("timeout done", 32'(DoneT), 32'd0);
        chk("timeout ctl", 32'({InvertT, ReverseT, LockedT}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
